// File: rtl/switch_game_pkg.sv
// Shared definitions for the switch puzzle: state encoding, board width and the target switch set.
// Kept common so the prompt and the checker always agree on TARGET_MASK.
package switch_game_pkg;

    localparam int unsigned SW_W  = 16;
    localparam int unsigned IDX_W = 4;

    localparam logic [SW_W-1:0] TARGET_MASK_DEF = 16'h2BC2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_t;

    // Confirmed switches solid, currently prompted switch follows the blink phase.
    function automatic logic [SW_W-1:0] prompt_led(
        input logic [SW_W-1:0]  conf,
        input logic             blink,
        input logic [IDX_W-1:0] idx
    );
        return conf | (SW_W'(blink) << idx);
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Blink time base: tick pulses once every TICK_DIV clocks, blink toggles on each tick.
// clr restarts both the count and the blink phase.
module blink_prescaler #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic clr,
    output logic tick,
    output logic blink
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_blink;

    assign tick  = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign blink = r_blink;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (clr) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (tick) begin
            r_cnt   <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/switch_prompt.sv
// Prompts the player through TARGET_MASK in ascending order, blinking the next switch's LED.
// Optional per-step timeout when SWITCH_PROMPT_TIMEOUT_EN is defined.
module switch_prompt
    import switch_game_pkg::*;
#(
    parameter logic [SW_W-1:0] TARGET_MASK   = TARGET_MASK_DEF,
    parameter int unsigned     TICK_DIV      = 25_000_000
`ifdef SWITCH_PROMPT_TIMEOUT_EN
    ,
    parameter int unsigned     TIMEOUT_TICKS = 20
`endif
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             arm,
    input  logic [SW_W-1:0]  sw,
    output logic [SW_W-1:0]  led,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             done
`ifdef SWITCH_PROMPT_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_p;
    logic [IDX_W-1:0] w_p_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [SW_W-1:0]  r_confirmed;
    logic [SW_W-1:0]  w_conf_nxt;
    logic [SW_W-1:0]  r_sw_meta;
    logic [SW_W-1:0]  r_sw_s;
    logic [SW_W-1:0]  r_led;
    logic [SW_W-1:0]  w_led_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_clr;
    logic             w_tick;
    logic             w_blink;
    logic             w_blink_nxt;
    logic             w_expire;
    logic             w_timeout_nxt;

    assign led  = r_led;
    assign idx  = r_idx;
    assign busy = r_busy;
    assign done = r_done;

    blink_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .clr     (w_clr),
        .tick    (w_tick),
        .blink   (w_blink)
    );

    // Two-flop synchroniser for the asynchronous slide switches.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sw_meta <= '0;
            r_sw_s    <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_s    <= r_sw_meta;
        end
    end

`ifdef SWITCH_PROMPT_TIMEOUT_EN
    localparam int unsigned STEP_W = $clog2(TIMEOUT_TICKS + 1);

    logic [STEP_W-1:0] r_step_cnt;
    logic              r_timeout;

    assign timeout  = r_timeout;
    assign w_expire = (r_state == SHOW) && w_tick &&
                      (r_step_cnt == STEP_W'(TIMEOUT_TICKS - 1));

    // Blink half-periods spent on the current step.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_step_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
            if (w_clr) begin
                r_step_cnt <= '0;
            end else if ((r_state == SHOW) && w_tick) begin
                r_step_cnt <= r_step_cnt + STEP_W'(1);
            end
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_p         <= '0;
            r_idx       <= '0;
            r_confirmed <= '0;
            r_led       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_p         <= w_p_nxt;
            r_idx       <= w_idx_nxt;
            r_confirmed <= w_conf_nxt;
            r_led       <= w_led_nxt;
            r_busy      <= (w_state_nxt == SEEK) || (w_state_nxt == SHOW);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_p_nxt       = r_p;
        w_idx_nxt     = '0;
        w_conf_nxt    = r_confirmed;
        w_clr         = 1'b0;
        w_timeout_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_conf_nxt = '0;
                if (arm) begin
                    w_state_nxt = SEEK;
                    w_p_nxt     = '0;
                end
            end
            SEEK: begin
                if (TARGET_MASK[r_p]) begin
                    w_state_nxt = SHOW;
                    w_idx_nxt   = r_p;
                    w_clr       = 1'b1;
                end else if (r_p == IDX_W'(SW_W - 1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_p_nxt = r_p + IDX_W'(1);
                end
            end
            SHOW: begin
                w_idx_nxt = r_idx;
                if (r_sw_s[r_idx]) begin
                    w_conf_nxt[r_idx] = 1'b1;
                    w_idx_nxt         = '0;
                    if (r_idx == IDX_W'(SW_W - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = SEEK;
                        w_p_nxt     = r_idx + IDX_W'(1);
                    end
                end else if (w_expire) begin
                    w_state_nxt   = IDLE;
                    w_idx_nxt     = '0;
                    w_conf_nxt    = '0;
                    w_timeout_nxt = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Dropping arm aborts from anywhere and outranks every other transition.
        if (!arm) begin
            w_state_nxt   = IDLE;
            w_p_nxt       = '0;
            w_idx_nxt     = '0;
            w_conf_nxt    = '0;
            w_clr         = 1'b0;
            w_timeout_nxt = 1'b0;
        end
    end

    // LED image for the state being entered, so it lines up with the blink flop.
    always_comb begin
        w_blink_nxt = w_clr ? 1'b0 : (w_blink ^ w_tick);
        w_led_nxt   = '0;
        case (w_state_nxt)
            IDLE:    w_led_nxt = '0;
            SEEK:    w_led_nxt = w_conf_nxt;
            SHOW:    w_led_nxt = prompt_led(w_conf_nxt, w_blink_nxt, w_idx_nxt);
            DONE:    w_led_nxt = TARGET_MASK;
            default: w_led_nxt = '0;
        endcase
    end

endmodule
